vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_timing.sv | 92 +++++++++
 tb/tb_vga_timing.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 1024x768@60 timing constants for the VGA timing generator and downstream drawing stages.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned H_FP     = 24;
    localparam int unsigned H_SYNC   = 136;
    localparam int unsigned H_BP     = 160;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 768;
    localparam int unsigned V_FP     = 3;
    localparam int unsigned V_SYNC   = 6;
    localparam int unsigned V_BP     = 29;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned CNT_W    = 11;

endpackage

// File: rtl/vga_timing.sv
// VGA 1024x768@60 timing generator: registered counters, sync/blank flags, and a frame counter.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [CNT_W-1:0]       hcount_out,
    output logic [CNT_W-1:0]       vcount_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   hblnk_out,
    output logic                   vblnk_out,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0]       h_nxt;
    logic [CNT_W-1:0]       v_nxt;
    logic                   hsync_nxt;
    logic                   vsync_nxt;
    logic                   hblnk_nxt;
    logic                   vblnk_nxt;
    logic                   frame_start_nxt;
    logic [FRAME_CNT_W-1:0] frame_cnt_nxt;

    always_comb begin
        h_nxt           = hcount_out;
        v_nxt           = vcount_out;
        hsync_nxt       = hsync_out;
        vsync_nxt       = vsync_out;
        hblnk_nxt       = hblnk_out;
        vblnk_nxt       = vblnk_out;
        frame_start_nxt = 1'b0;
        frame_cnt_nxt   = frame_cnt;

        if (en) begin
            if (hcount_out == H_LAST) begin
                h_nxt = '0;
                if (vcount_out == V_LAST) begin
                    v_nxt           = '0;
                    frame_start_nxt = 1'b1;
                    frame_cnt_nxt   = frame_cnt + FRAME_CNT_W'(1);
                end else begin
                    v_nxt = vcount_out + CNT_W'(1);
                end
            end else begin
                h_nxt = hcount_out + CNT_W'(1);
            end

            // Flags derive from the next counts so they land in the same cycle as those counts.
            hblnk_nxt = (h_nxt >= H_BLNK_BEG);
            hsync_nxt = (h_nxt >= H_SYNC_BEG) && (h_nxt <= H_SYNC_END);
            vblnk_nxt = (v_nxt >= V_BLNK_BEG);
            vsync_nxt = (v_nxt >= V_SYNC_BEG) && (v_nxt <= V_SYNC_END);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hcount_out  <= h_nxt;
            vcount_out  <= v_nxt;
            hsync_out   <= hsync_nxt;
            vsync_out   <= vsync_nxt;
            hblnk_out   <= hblnk_nxt;
            vblnk_out   <= vblnk_nxt;
            frame_start <= frame_start_nxt;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: counter-level reference model checked every cycle plus directed literal checks.
module tb_vga_timing;

    logic        clk;
    logic        rst;
    logic        en;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic        frame_start;
    logic [15:0] frame_cnt;

    vga_timing #(.FRAME_CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .hblnk_out   (hblnk_out),
        .vblnk_out   (vblnk_out),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    bit chk_on = 1'b0;

    // Reference position: pixel/line/frame counts only; flags follow from the raster rules.
    int mh = 0, mv = 0, mfc = 0;
    bit mfs = 1'b0;

    function automatic logic hb_of(input int h); return h >= 1024; endfunction
    function automatic logic hs_of(input int h); return h >= 1048 && h <= 1183; endfunction
    function automatic logic vb_of(input int v); return v >= 768; endfunction
    function automatic logic vs_of(input int v); return v >= 771 && v <= 776; endfunction

    function automatic logic [63:0] pk(input int h, input int v, input logic hs, input logic vs,
                                       input logic hb, input logic vb, input logic fs, input int fc);
        logic [10:0] h11, v11;
        logic [15:0] fc16;
        h11  = h[10:0];
        v11  = v[10:0];
        fc16 = fc[15:0];
        return {21'd0, h11, v11, hs, vs, hb, vb, fs, fc16};
    endfunction

    function automatic logic [63:0] dut_pk();
        return {21'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                frame_start, frame_cnt};
    endfunction

    function automatic logic [63:0] model_pk();
        return pk(mh, mv, hs_of(mh), vs_of(mv), hb_of(mh), vb_of(mv), mfs, mfc);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h (h/v/hs/vs/hb/vb/fs/fc packed) at %0t",
                      name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mh = 0; mv = 0; mfc = 0; mfs = 1'b0;
        end else if (en) begin
            mfs = (mh == 1343) && (mv == 805);
            if (mh == 1343) begin
                mh = 0;
                mv = (mv == 805) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (mfs) mfc = (mfc + 1) % 65536;
        end else begin
            mfs = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) check("cycle", dut_pk(), model_pk());
    end

    logic [10:0] jh, jv;
    logic [15:0] jfc;
    logic        jhs, jvs, jhb, jvb;

    // Relocate the raster by forcing state through one hold cycle, so the stored value matches after release.
    task jump(input int h, input int v, input int fc);
        @(negedge clk);
        en = 1'b0;
        #1;
        jh = h[10:0]; jv = v[10:0]; jfc = fc[15:0];
        jhs = hs_of(h); jvs = vs_of(v); jhb = hb_of(h); jvb = vb_of(v);
        force dut.hcount_out  = jh;
        force dut.vcount_out  = jv;
        force dut.frame_cnt   = jfc;
        force dut.hsync_out   = jhs;
        force dut.vsync_out   = jvs;
        force dut.hblnk_out   = jhb;
        force dut.vblnk_out   = jvb;
        force dut.frame_start = 1'b0;
        mh = h; mv = v; mfc = fc; mfs = 1'b0;
        @(posedge clk);
        #1;
        release dut.hcount_out;
        release dut.vcount_out;
        release dut.frame_cnt;
        release dut.hsync_out;
        release dut.vsync_out;
        release dut.hblnk_out;
        release dut.vblnk_out;
        release dut.frame_start;
        en = 1'b1;
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("run_to_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset_state", dut_pk(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        check("first_step", dut_pk(), pk(1, 0, 0, 0, 0, 0, 0, 0));

        run_to(1023, 0); check("h1023_blank", {63'd0, hblnk_out}, 64'd0);
        @(negedge clk);  check("h1024_blank", {63'd0, hblnk_out}, 64'd1);
        run_to(1047, 0); check("h1047_sync",  {63'd0, hsync_out}, 64'd0);
        @(negedge clk);  check("h1048_sync",  {63'd0, hsync_out}, 64'd1);
        run_to(1183, 0); check("h1183_sync",  {63'd0, hsync_out}, 64'd1);
        @(negedge clk);  check("h1184_sync",  {63'd0, hsync_out}, 64'd0);

        jump(1340, 10, 0);
        run_to(1343, 10); check("line_end", dut_pk(), pk(1343, 10, 0, 0, 1, 0, 0, 0));
        @(negedge clk);   check("line_wrap", dut_pk(), pk(0, 11, 0, 0, 0, 0, 0, 0));

        jump(1340, 766, 0);
        run_to(1343, 767); check("v767_blank", {63'd0, vblnk_out}, 64'd0);
        @(negedge clk);    check("v768_blank", dut_pk(), pk(0, 768, 0, 0, 0, 1, 0, 0));
        run_to(1343, 770); check("v770_sync", {63'd0, vsync_out}, 64'd0);
        @(negedge clk);    check("v771_sync", {63'd0, vsync_out}, 64'd1);
        run_to(1343, 776); check("v776_sync", {63'd0, vsync_out}, 64'd1);
        @(negedge clk);    check("v777_sync", {63'd0, vsync_out}, 64'd0);

        jump(1340, 805, 0);
        run_to(0, 0); check("frame_wrap", dut_pk(), pk(0, 0, 0, 0, 0, 0, 1, 1));
        en = 1'b0;
        @(negedge clk); check("frame_hold", dut_pk(), pk(0, 0, 0, 0, 0, 0, 0, 1));
        en = 1'b1;
        @(negedge clk); check("frame_after", dut_pk(), pk(1, 0, 0, 0, 0, 0, 0, 1));

        jump(1340, 805, 16'hFFFF);
        run_to(0, 0); check("frame_cnt_wrap", dut_pk(), pk(0, 0, 0, 0, 0, 0, 1, 0));

        jump(495, 300, 5);
        run_to(500, 300);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold", dut_pk(), pk(500, 300, 0, 0, 0, 0, 0, 5));
        end
        en = 1'b1;
        @(negedge clk); check("hold_resume", dut_pk(), pk(501, 300, 0, 0, 0, 0, 0, 5));

        for (int i = 0; i < 60; i++) begin
            en = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        en = 1'b1;

        jump(695, 400, 7);
        run_to(700, 400);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk); check("mid_reset", dut_pk(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk); check("post_reset_hold", dut_pk(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        en = 1'b1;
        @(negedge clk); check("post_reset_run", dut_pk(), pk(1, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
